// File: rtl/fb_stream_writer.sv
// Packs a valid/ready byte stream into 12-bit {B,G,R} pixels and drives the
// 128x128 frame-buffer write port, optionally accepting bytes only in vblank.
module fb_stream_writer #(
  parameter int unsigned ADDR_BITS   = 7,
  parameter bit          GATE_VBLANK = 1'b1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [7:0]           s_data,
  input  logic                 s_valid,
  input  logic                 s_sof,
  output logic                 s_ready,
  input  logic                 vblank,
  output logic [ADDR_BITS-1:0] wr_row,
  output logic [ADDR_BITS-1:0] wr_col,
  output logic [11:0]          wr_rgb,
  output logic                 wr_en,
  output logic                 frame_done,
  output logic                 busy
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned RGB_W  = 12;
  localparam logic [ADDR_BITS-1:0] ADDR_MAX = '1;

  typedef enum logic [1:0] {
    ST_LO = 2'd0,
    ST_HI = 2'd1,
    ST_WR = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [BYTE_W-1:0]    hold_q, hold_d;
  logic [ADDR_BITS-1:0] row_q, row_d;
  logic [ADDR_BITS-1:0] col_q, col_d;
  logic [ADDR_BITS-1:0] wr_row_d, wr_col_d;
  logic [RGB_W-1:0]     wr_rgb_d;
  logic                 wr_en_d, frame_done_d, busy_d;
  logic                 accept;

  // Ready is the only combinational output; forced low while in reset.
  assign s_ready = resetn && (state_q != ST_WR) && (!GATE_VBLANK || vblank);
  assign accept  = s_valid && s_ready;

  // Next-state, address counter and write-port logic.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    row_d        = row_q;
    col_d        = col_q;
    wr_row_d     = wr_row;
    wr_col_d     = wr_col;
    wr_rgb_d     = wr_rgb;
    wr_en_d      = 1'b0;
    frame_done_d = 1'b0;

    case (state_q)
      ST_LO: begin
        if (accept) begin
          hold_d  = s_data;
          state_d = ST_HI;
          if (s_sof) begin
            row_d = '0;
            col_d = '0;
          end
        end
      end
      ST_HI: begin
        if (accept) begin
          if (s_sof) begin
            // Restart the frame: this byte replaces the pending low byte.
            hold_d = s_data;
            row_d  = '0;
            col_d  = '0;
          end else begin
            wr_row_d     = row_q;
            wr_col_d     = col_q;
            wr_rgb_d     = {s_data[3:0], hold_q};
            wr_en_d      = 1'b1;
            frame_done_d = (row_q == ADDR_MAX) && (col_q == ADDR_MAX);
            state_d      = ST_WR;
          end
        end
      end
      ST_WR: begin
        state_d = ST_LO;
        col_d   = col_q + ADDR_BITS'(1);
        if (col_q == ADDR_MAX) begin
          row_d = row_q + ADDR_BITS'(1);
        end
      end
      default: begin
        state_d = ST_LO;
      end
    endcase

    busy_d = (state_d != ST_LO) || (row_d != '0) || (col_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_LO;
      hold_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      wr_row     <= '0;
      wr_col     <= '0;
      wr_rgb     <= '0;
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      row_q      <= row_d;
      col_q      <= col_d;
      wr_row     <= wr_row_d;
      wr_col     <= wr_col_d;
      wr_rgb     <= wr_rgb_d;
      wr_en      <= wr_en_d;
      frame_done <= frame_done_d;
      busy       <= busy_d;
    end
  end

endmodule
